pll_lock_supervisor: RTL and testbench

// Controller end of the PLL rst/locked interface. Drives the PLL reset, watches
// the asynchronous locked flag, qualifies lock stability, releases the core

---
 rtl/pll_lock_if.sv | 19 +
 rtl/pll_lock_supervisor.sv | 162 ++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_if.sv
// PLL control/status bundle between the lock supervisor (master) and the PLL side (slave).
interface pll_lock_if;
    logic       pll_locked;
    logic       pll_rst;
    logic       core_rst;
    logic       ready;
    logic       fault;
    logic [2:0] state;

    modport master (
        input  pll_locked,
        output pll_rst, core_rst, ready, fault, state
    );

    modport slave (
        output pll_locked,
        input  pll_rst, core_rst, ready, fault, state
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: holds PLL reset, qualifies lock, releases core reset, retries or faults.
// Optional PLL_RETRY_COUNT_EN adds a saturating lifetime retry counter port (retry_total).
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4
) (
    input  logic          refclk,
    input  logic          rst,
    pll_lock_if.master    pll
`ifdef PLL_RETRY_COUNT_EN
    ,
    output logic [7:0]    retry_total
`endif
);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam int MAXP_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAXP   = (MAXP_A > STABLE_CYCLES) ? MAXP_A : STABLE_CYCLES;
    localparam int CW     = (MAXP > 1) ? $clog2(MAXP) : 1;

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [7:0]    RETRY_MAX   = 8'(MAX_RETRIES);

    state_t        state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic [7:0]    retry_r, retry_nxt_s;
    logic          retry_ev_s;
    logic [1:0]    sync_r;
    logic          lk_s;
    logic          pll_rst_r, core_rst_r, ready_r, fault_r;

    assign lk_s = sync_r[1];

    // Two-flop synchronizer for the asynchronous PLL lock flag.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], pll.pll_locked};
        end
    end

    // Next-state, counter and retry bookkeeping.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        retry_nxt_s = retry_r;
        retry_ev_s  = 1'b0;
        case (state_r)
            RESET_PLL: begin
                if (cnt_r == RST_LAST) begin
                    state_nxt_s = WAIT_LOCK;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = RESET_PLL;
                end
            end
            WAIT_LOCK: begin
                if (lk_s) begin
                    state_nxt_s = STABLE;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == TO_LAST) begin
                    retry_ev_s  = 1'b1;
                end else begin
                    state_nxt_s = WAIT_LOCK;
                end
            end
            STABLE: begin
                if (!lk_s) begin
                    state_nxt_s = WAIT_LOCK;
                    cnt_nxt_s   = '0;
                end else if (cnt_r == STABLE_LAST) begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = '0;
                    retry_nxt_s = 8'd0;
                end else begin
                    state_nxt_s = STABLE;
                end
            end
            RUN: begin
                cnt_nxt_s = '0;
                if (!lk_s) begin
                    retry_ev_s = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FAULT: begin
                cnt_nxt_s   = '0;
                state_nxt_s = FAULT;
            end
            default: begin
                cnt_nxt_s   = '0;
                state_nxt_s = FAULT;
            end
        endcase
        // Timeouts and lock losses share one retry path.
        if (retry_ev_s) begin
            retry_nxt_s = retry_r + 8'd1;
            cnt_nxt_s   = '0;
            state_nxt_s = (retry_nxt_s == RETRY_MAX) ? FAULT : RESET_PLL;
        end else begin
            retry_nxt_s = retry_nxt_s;
        end
    end

    // State, counters and outputs; outputs decode the next state so they track it exactly.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_r    <= RESET_PLL;
            cnt_r      <= '0;
            retry_r    <= 8'd0;
            pll_rst_r  <= 1'b1;
            core_rst_r <= 1'b1;
            ready_r    <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            retry_r    <= retry_nxt_s;
            pll_rst_r  <= (state_nxt_s == RESET_PLL) || (state_nxt_s == FAULT);
            core_rst_r <= (state_nxt_s != RUN);
            ready_r    <= (state_nxt_s == RUN);
            fault_r    <= (state_nxt_s == FAULT);
        end
    end

    assign pll.pll_rst  = pll_rst_r;
    assign pll.core_rst = core_rst_r;
    assign pll.ready    = ready_r;
    assign pll.fault    = fault_r;
    assign pll.state    = state_r;

`ifdef PLL_RETRY_COUNT_EN
    logic [7:0] total_r;

    // Lifetime retry counter, saturating.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            total_r <= 8'd0;
        end else if (retry_ev_s && (total_r != 8'hFF)) begin
            total_r <= total_r + 8'd1;
        end else begin
            total_r <= total_r;
        end
    end

    assign retry_total = total_r;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor (RST=4, TIMEOUT=32, STABLE=8, MAX_RETRIES=3).
module tb_pll_lock_supervisor;

    logic refclk;
    logic rst;
    int   n_total;
    int   n_pass;

    pll_lock_if pll();

`ifdef PLL_RETRY_COUNT_EN
    logic [7:0] retry_total;
`endif

    pll_lock_supervisor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (3)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll         (pll)
`ifdef PLL_RETRY_COUNT_EN
        ,
        .retry_total (retry_total)
`endif
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Advance one rising edge, then settle at the following falling edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge refclk);
            @(negedge refclk);
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"},    8'(pll.state),    8'd0);
        check({tag, "_pll_rst"},  8'(pll.pll_rst),  8'd1);
        check({tag, "_core_rst"}, 8'(pll.core_rst), 8'd1);
        check({tag, "_ready"},    8'(pll.ready),    8'd0);
        check({tag, "_fault"},    8'(pll.fault),    8'd0);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1;
        pll.pll_locked = 1'b0;
        tick(3);
        check_idle("reset");

        // Release reset: PLL reset held for exactly 4 edges.
        rst = 1'b0;
        tick(3);
        check("prst_hold_pll_rst", 8'(pll.pll_rst), 8'd1);
        check("prst_hold_ready",   8'(pll.ready),   8'd0);
        tick(1);
        check("prst_end_pll_rst",  8'(pll.pll_rst), 8'd0);
        check("prst_end_state",    8'(pll.state),   8'd1);
        check("prst_end_core_rst", 8'(pll.core_rst), 8'd1);

        // Lock 10 cycles after pll_rst fell; RUN 11 edges after the rise.
        tick(9);
        check("wait_state", 8'(pll.state), 8'd1);
        pll.pll_locked = 1'b1;
        tick(3);
        check("stable_state", 8'(pll.state), 8'd2);
        tick(7);
        check("pre_run_ready", 8'(pll.ready), 8'd0);
        tick(1);
        check("run_ready",    8'(pll.ready),    8'd1);
        check("run_core_rst", 8'(pll.core_rst), 8'd0);
        check("run_state",    8'(pll.state),    8'd3);

        // Lock loss #1 from RUN.
        pll.pll_locked = 1'b0;
        tick(2);
        check("loss1_ready_still", 8'(pll.ready), 8'd1);
        tick(1);
        check("loss1_core_rst", 8'(pll.core_rst), 8'd1);
        check("loss1_state",    8'(pll.state),    8'd0);
        check("loss1_pll_rst",  8'(pll.pll_rst),  8'd1);
        tick(3);
        check("loss1_pll_rst_hold", 8'(pll.pll_rst), 8'd1);
        tick(1);
        check("loss1_pll_rst_end", 8'(pll.pll_rst), 8'd0);
        pll.pll_locked = 1'b1;
        tick(11);
        check("relock1_ready", 8'(pll.ready), 8'd1);

        // Lock loss #2, then a 1-cycle glitch during STABLE.
        pll.pll_locked = 1'b0;
        tick(3);
        check("loss2_state", 8'(pll.state), 8'd0);
        tick(4);
        check("loss2_wait", 8'(pll.state), 8'd1);
        pll.pll_locked = 1'b1;
        tick(3);
        check("glitch_pre_state", 8'(pll.state), 8'd2);
        tick(3);
        pll.pll_locked = 1'b0;
        tick(1);
        pll.pll_locked = 1'b1;
        tick(1);
        check("glitch_still_stable", 8'(pll.state), 8'd2);
        tick(1);
        check("glitch_back_wait", 8'(pll.state),   8'd1);
        check("glitch_pll_rst",   8'(pll.pll_rst), 8'd0);
        check("glitch_ready",     8'(pll.ready),   8'd0);
        tick(1);
        check("glitch_restable", 8'(pll.state), 8'd2);
        tick(7);
        check("glitch_pre_run", 8'(pll.ready), 8'd0);
        tick(1);
        check("glitch_run_ready", 8'(pll.ready), 8'd1);
        check("glitch_run_state", 8'(pll.state), 8'd3);

        // Lock loss #3: retry count was cleared in RUN, so no fault.
        pll.pll_locked = 1'b0;
        tick(3);
        check("loss3_state", 8'(pll.state), 8'd0);
        check("loss3_fault", 8'(pll.fault), 8'd0);
        tick(4);
        pll.pll_locked = 1'b1;
        tick(11);
        check("relock3_ready", 8'(pll.ready), 8'd1);

        // Reset mid-RUN, then three lock timeouts lead to FAULT.
        @(negedge refclk);
        rst = 1'b1;
        pll.pll_locked = 1'b0;
        tick(1);
        check_idle("midrst");
        rst = 1'b0;
        tick(36);
        check("to1_state",   8'(pll.state),   8'd0);
        check("to1_pll_rst", 8'(pll.pll_rst), 8'd1);
        tick(36);
        check("to2_state", 8'(pll.state), 8'd0);
        check("to2_fault", 8'(pll.fault), 8'd0);
        tick(35);
        check("to3_pre_state", 8'(pll.state), 8'd1);
        check("to3_pre_fault", 8'(pll.fault), 8'd0);
        tick(1);
        check("fault_state",    8'(pll.state),    8'd4);
        check("fault_flag",     8'(pll.fault),    8'd1);
        check("fault_pll_rst",  8'(pll.pll_rst),  8'd1);
        check("fault_core_rst", 8'(pll.core_rst), 8'd1);
        pll.pll_locked = 1'b1;
        tick(20);
        check("fault_sticky_state", 8'(pll.state), 8'd4);
        check("fault_sticky_ready", 8'(pll.ready), 8'd0);
        rst = 1'b1;
        pll.pll_locked = 1'b0;
        tick(1);
        check_idle("fault_rst");
        rst = 1'b0;

`ifdef PLL_RETRY_COUNT_EN
        check("total_reset", retry_total, 8'd0);
        for (int k = 0; k < 300; k++) begin
            int guard;
            pll.pll_locked = 1'b1;
            guard = 0;
            while (!pll.ready && guard < 60) begin
                tick(1);
                guard++;
            end
            if (guard >= 60) begin
                check("total_lock_timeout", 8'(pll.ready), 8'd1);
                break;
            end
            pll.pll_locked = 1'b0;
            tick(3);
        end
        check("total_sat", retry_total, 8'd255);
        rst = 1'b1;
        tick(1);
        check("total_clear", retry_total, 8'd0);
        rst = 1'b0;
`endif

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
